// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx
// Device-side PS/2 transmitter. Bytes accepted on a valid/ready handshake are
// serialised into 11-bit device-to-host frames:
//   start(0), data[0..7] LSB first, odd parity (~^byte), stop(1).
// Both PS/2 lines are driven from registers and idle high. Every bit slot has
// a high phase and then a low phase, each HALF_PER cycles long. A gap of
// GAP_CYC idle-high cycles separates consecutive frames.
//
// Parameters:
//   HALF_PER  system-clock cycles per PS/2 clock half-period (>= 2)
//   GAP_CYC   idle cycles between the stop bit and the next start bit (>= 1)
//
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset (both lines go high at once)
//   byte_i     scan-code byte, captured on valid_i & ready_o
//   valid_i    byte_i valid
//   ready_o    a byte can be accepted this cycle
//   ps2_clk_o  PS/2 clock, idle high
//   ps2_dat_o  PS/2 data, idle high, changes only while ps2_clk_o is high
//   busy_o     frame or gap in progress, or queued bytes present
//
// Build option:
//   PS2_TX_FIFO_EN  defined:   a 4-entry byte FIFO sits in front of the
//                              serialiser, and ready_o = FIFO not full.
//                   undefined: the serialiser frame register is the only
//                              storage, and ready_o = (state == IDLE).
module ps2_dev_tx #(
  parameter int unsigned HALF_PER = 2000,
  parameter int unsigned GAP_CYC  = 4000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  output logic       busy_o
);

  localparam int unsigned HW = (HALF_PER > 2) ? $clog2(HALF_PER) : 1;
  localparam int unsigned GW = $clog2(GAP_CYC + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PER - 1);
  // The outputs are registered and lag the state by one cycle. The IDLE cycle
  // that launches the next frame therefore counts as one of the gap cycles,
  // so the GAP state itself lasts GAP_CYC-1 cycles.
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 1) ? (GAP_CYC - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;   // 0: clock-high phase, 1: clock-low phase
  logic [3:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [10:0]   frame_q, frame_d;   // {stop, parity, data, start}
  logic          clk_q, dat_q;

  logic          idle_w;
  logic          launch;
  logic [7:0]    launch_byte;
  logic          q_busy;

  assign idle_w = (state_q == S_IDLE);

`ifdef PS2_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] cnt_q;
  logic       fifo_empty, fifo_full, push, pop;

  assign fifo_empty  = (cnt_q == 3'd0);
  assign fifo_full   = (cnt_q == 3'd4);
  assign ready_o     = ~fifo_full;
  // Queued bytes launch ahead of a byte arriving on the same edge. A byte that
  // arrives while IDLE and empty launches directly, bypassing the FIFO.
  assign launch      = idle_w & (~fifo_empty | valid_i);
  assign launch_byte = fifo_empty ? byte_i : fifo_q[rd_q];
  assign pop         = launch & ~fifo_empty;
  assign push        = valid_i & ~fifo_full & ~(launch & fifo_empty);
  assign q_busy      = ~fifo_empty;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 2'd1;
      if (pop)  rd_q <= rd_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= byte_i;
  end
`else
  assign ready_o     = idle_w;
  assign launch      = idle_w & valid_i;
  assign launch_byte = byte_i;
  assign q_busy      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_SEND;
          half_d  = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          frame_d = {1'b1, ~^launch_byte, launch_byte, 1'b0};
        end
      end
      S_SEND: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 4'd10) begin
              bit_d = '0;
              gap_d = '0;
              state_d = (GAP_CYC > 1) ? S_GAP : S_IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      frame_q <= '1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
    end
  end

  // Registered line drivers keep both lines glitch-free. The data bit and the
  // rising clock change together at slot boundaries, so data never moves while
  // the clock is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_q <= 1'b1;
      dat_q <= 1'b1;
    end else if (state_q == S_SEND) begin
      clk_q <= ~phase_q;
      dat_q <= frame_q[bit_q];
    end else begin
      clk_q <= 1'b1;
      dat_q <= 1'b1;
    end
  end

  assign ps2_clk_o = clk_q;
  assign ps2_dat_o = dat_q;
  assign busy_o    = ~idle_w | q_busy;

endmodule

// File: tb/tb_ps2_dev_tx.sv
module tb_ps2_dev_tx;

  localparam int unsigned H = 4;
  localparam int unsigned G = 8;
  localparam int FRAME_LEN = 22 * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = '0;
  logic       valid = 1'b0;
  logic       ready, ps2_clk, ps2_dat, busy;

  ps2_dev_tx #(.HALF_PER(H), .GAP_CYC(G)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .byte_i   (byte_in),
    .valid_i  (valid),
    .ready_o  (ready),
    .ps2_clk_o(ps2_clk),
    .ps2_dat_o(ps2_dat),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic void check(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vt [7];
  vec_t v6 [6];

  // Scoreboard of expected 11-bit frames, {stop, parity, data, start}.
  logic [10:0] sb [$];

  int pcyc = 0;
  always @(posedge clk) pcyc++;

  // Line monitor, sampled on the falling system-clock edge.
  int          mcyc = 0;
  bit          mon_in_frame = 0;
  int          mon_nbits = 0;
  logic [10:0] mon_bits = '0;
  int          mon_start = 0;
  int          mon_end = 0;
  bit          mon_have_end = 0;
  int          mon_end_epoch = 0;
  int          gap_epoch = 0;
  int          viol = 0;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;
  logic [10:0] exp_fr;

  always @(negedge clk) begin
    mcyc++;
    if (!rst_n) begin
      mon_in_frame = 0;
      mon_nbits    = 0;
      mon_have_end = 0;
      prev_clk     = 1'b1;
      prev_dat     = 1'b1;
    end else begin
      if (!prev_clk && !ps2_clk && (ps2_dat != prev_dat)) viol++;
      if (!mon_in_frame && ps2_clk && !ps2_dat) begin
        mon_in_frame = 1;
        mon_nbits    = 0;
        mon_start    = mcyc;
        if (mon_have_end && (mon_end_epoch == gap_epoch))
          check("gap_cycles", mcyc - mon_end, int'(G));
      end
      if (prev_clk && !ps2_clk) begin
        if (!mon_in_frame) viol++;
        else begin
          if (mon_nbits < 11) mon_bits[mon_nbits] = ps2_dat;
          mon_nbits++;
        end
      end
      if (mon_in_frame && (mon_nbits == 11) && !prev_clk && ps2_clk) begin
        check("frame_len", mcyc - mon_start, FRAME_LEN);
        if (sb.size() == 0) begin
          check("unexpected_frame", int'(mon_bits), -1);
        end else begin
          exp_fr = sb.pop_front();
          check("frame_bits", int'(mon_bits), int'(exp_fr));
        end
        mon_in_frame  = 0;
        mon_end       = mcyc;
        mon_have_end  = 1;
        mon_end_epoch = gap_epoch;
      end
      prev_clk = ps2_clk;
      prev_dat = ps2_dat;
    end
  end

  int last_acc = 0;

  // Hold valid until accepted; leaves valid high so calls can run back-to-back.
  task automatic send(input logic [7:0] d, input logic par, input bit chk_interval);
    @(negedge clk);
    byte_in = d;
    valid   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (ready) begin
        sb.push_back({1'b1, par, d, 1'b0});
        @(posedge clk);
        #1;
`ifndef PS2_TX_FIFO_EN
        check("ready_low_after_accept", int'(ready), 0);
        if (chk_interval) check("accept_interval", pcyc - last_acc, FRAME_LEN + int'(G));
`endif
        last_acc = pcyc;
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 0, 1);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (!busy && !mon_in_frame) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  int  idle_bad;
  bit  hit;

  initial begin
    vt = '{'{8'h1C, 1'b0}, '{8'h00, 1'b1}, '{8'hFF, 1'b1}, '{8'hA5, 1'b1},
           '{8'h80, 1'b0}, '{8'h7F, 1'b0}, '{8'h3C, 1'b1}};
    v6 = '{'{8'h01, 1'b0}, '{8'h02, 1'b0}, '{8'h03, 1'b1},
           '{8'h04, 1'b0}, '{8'h05, 1'b1}, '{8'h06, 1'b1}};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_dat", int'(ps2_dat), 1);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency of 0x1C from an empty, idle block.
    byte_in = 8'h1C;
    valid   = 1'b1;
    check("ready_idle", int'(ready), 1);
    sb.push_back(11'b10000111000);
    @(posedge clk);                  // accept edge T
    #1;
    valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("dat_at_T", int'(ps2_dat), 1);
`ifdef PS2_TX_FIFO_EN
    check("ready_after_accept_fifo", int'(ready), 1);
`else
    check("ready_after_accept", int'(ready), 0);
`endif
    @(posedge clk);
    #1;
    check("start_bit_T1", int'(ps2_dat), 0);
    check("clk_high_T1", int'(ps2_clk), 1);
    repeat (H - 1) @(posedge clk);
    #1;
    check("clk_high_before_fall", int'(ps2_clk), 1);
    @(posedge clk);
    #1;
    check("clk_fall_T1_H", int'(ps2_clk), 0);
    wait_idle();

    // Table vectors, streamed back-to-back.
    gap_epoch++;
    for (int i = 0; i < 7; i++) send(vt[i].data, vt[i].par, i > 0);
    valid = 1'b0;
    wait_idle();

    // Six bytes with valid held high.
    gap_epoch++;
    for (int i = 0; i < 6; i++) begin
      send(v6[i].data, v6[i].par, i > 0);
`ifdef PS2_TX_FIFO_EN
      if (i == 3) check("ready_with_3_queued", int'(ready), 1);
      if (i == 4) check("ready_full_4_queued", int'(ready), 0);
`endif
    end
    valid = 1'b0;
    wait_idle();

    // Reset during data bit 3.
    gap_epoch++;
    send(8'hA5, 1'b1, 0);
    valid = 1'b0;
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (mon_in_frame && (mon_nbits == 4) && ps2_clk) hit = 1;
    end
    check("reached_data_bit3", int'(hit), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_clk", int'(ps2_clk), 1);
    check("rst_mid_dat", int'(ps2_dat), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(ready), 1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (!ps2_clk || !ps2_dat || busy) idle_bad++;
    end
    check("idle_after_reset", idle_bad, 0);

    check("dat_stable_clk_low", viol, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
